gate_truth_sequencer: RTL and testbench
=======================================

Name: gate_truth_sequencer

Overview:
Self-checking stimulus/response stage for a 2-input combinational gate such as nor_gate. It drives the gate's a/b inputs through all four input combinations and samples the gate output y. It compares each sample against a parameterised expected truth table and reports pass/fail plus an error count. It sits directly around the gate in the basic-gates bench: upstream as the driver of a/b, downstream as the consumer of y.

Parameters:
HOLD_CYCLES, 4, clock cycles each vector is held before y_in is sampled; legal range 1..255.
EXP_TABLE, 4'b0001, expected y for vector index {a,b}; bit i is the expected output for index i. The default is the NOR table.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
y_in  input  1  gate output under test, combinational from a/b
a  output  1  gate input a, registered; vector index bit 1
b  output  1  gate input b, registered; vector index bit 0
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse at end of run
pass  output  1  high when the last run had err_count==0
err_count  output  3  mismatches in the last run, 0..4
vec_idx  output  2  index of the vector currently driven

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, hold counter 0, and a, b, busy, done, pass, err_count, vec_idx all 0.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - a=b=0, busy=0.
  - start=1 at an edge (edge E0) moves to DRIVE, sets vec_idx=0 and a,b=0,0, clears err_count and pass, sets busy=1.
- DRIVE:
  - {a,b} always equals vec_idx.
  - The hold counter counts 0..HOLD_CYCLES-1.
  - On the edge where the counter is HOLD_CYCLES-1, y_in is sampled and compared with EXP_TABLE[vec_idx]; on mismatch err_count increments by 1.
  - On that same edge, if vec_idx<3: vec_idx increments, a/b update and the counter returns to 0. If vec_idx==3: go to DONE.
  - Vector k is therefore driven from edge E0+k*HOLD_CYCLES and sampled at edge E0+(k+1)*HOLD_CYCLES.
- DONE:
  - Entered at edge E0+4*HOLD_CYCLES; lasts exactly one cycle.
  - done=1, busy=0, a=b=0, vec_idx=0, pass=(err_count==0).
  - Then return to IDLE.
- Hold of results: err_count and pass hold their values until the next accepted start.
- start handling: start in DRIVE or DONE is ignored and not queued. start held high continuously restarts a run in the cycle after DONE.
- err_count cannot exceed 4, so no saturation logic is needed.
- Reset mid-run: immediate return to reset values; the partial result is discarded.
- HOLD_CYCLES=1: one vector per cycle; the run takes 4 cycles plus 1 DONE cycle.
- y_in is used only at sample edges; the value at every other time is don't-care.

Optional Feature:
Macro GATE_SEQ_FAIL_MASK_EN.
- Defined: adds output port fail_mask (4 bits).
  - Bit i is set when vector i mismatched.
  - Cleared on accepted start and on reset.
  - Held with err_count.
  - err_count always equals the popcount of fail_mask.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, y_in driven by a real nor_gate from a/b, start pulse at E0 -> done=1 exactly in the cycle after edge E0+16, pass=1, err_count=0, fail_mask=4'b0000; a/b sequence 00,01,10,11, each held 4 cycles.
- y_in tied 0 -> err_count=1, pass=0, fail_mask=4'b0001.
- y_in tied 1 -> err_count=3, pass=0, fail_mask=4'b1110.
- y_in=a|b (OR gate) -> err_count=4, pass=0, fail_mask=4'b1111.
- Start pulses while busy, then assert rst_n=0 during vector 2:
  - extra start pulses -> no effect on vec_idx/timing;
  - rst_n=0 -> all outputs 0 immediately (asynchronous);
  - after release, a new start -> clean full run with pass=1.
- HOLD_CYCLES=1, EXP_TABLE=4'b0111 (NAND), y_in from a NAND -> done in the cycle after edge E0+4, pass=1; a/b change every cycle.

Source files
------------

// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer
// Drives a 2-input gate under test through the input vectors {a,b} = 00,01,10,11.
// Each vector is held for HOLD_CYCLES clocks. At the end of the hold window the
// gate output y_in is compared with EXP_TABLE[{a,b}]. The stage reports an error
// count, a pass flag and a one-cycle done pulse.
// Optional build macro GATE_SEQ_FAIL_MASK_EN adds a per-vector fail_mask output.
module gate_truth_sequencer #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [3:0]  EXP_TABLE   = 4'b0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] vec_idx
`ifdef GATE_SEQ_FAIL_MASK_EN
    ,
    output logic [3:0] fail_mask
`endif
);

    // Terminal value of the hold counter; the sample edge is the one leaving it.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic [1:0] vec_idx_nxt;
    logic       a_nxt, b_nxt;
    logic       busy_nxt, done_nxt, pass_nxt;
    logic [2:0] err_count_nxt;
    logic       mismatch;
    logic [2:0] err_inc;
`ifdef GATE_SEQ_FAIL_MASK_EN
    logic [3:0] fail_mask_nxt;
`endif

    // Compare the sampled gate output against the expected truth-table bit.
    function automatic logic is_mismatch(input logic y, input logic [1:0] idx);
        return y != EXP_TABLE[idx];
    endfunction

    // Mismatch of the current sample and the error count it would produce.
    always_comb begin
        mismatch = is_mismatch(y_in, vec_idx);
        err_inc  = err_count + {2'b00, mismatch};
    end

    // Next-state and next-output logic. All outputs are registered from these values.
    always_comb begin
        state_nxt     = state;
        hold_cnt_nxt  = hold_cnt;
        vec_idx_nxt   = vec_idx;
        a_nxt         = a;
        b_nxt         = b;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        pass_nxt      = pass;
        err_count_nxt = err_count;
`ifdef GATE_SEQ_FAIL_MASK_EN
        fail_mask_nxt = fail_mask;
`endif
        case (state)
            S_IDLE: begin
                a_nxt    = 1'b0;
                b_nxt    = 1'b0;
                busy_nxt = 1'b0;
                if (start) begin
                    state_nxt     = S_DRIVE;
                    hold_cnt_nxt  = 8'd0;
                    vec_idx_nxt   = 2'd0;
                    busy_nxt      = 1'b1;
                    pass_nxt      = 1'b0;
                    err_count_nxt = 3'd0;
`ifdef GATE_SEQ_FAIL_MASK_EN
                    fail_mask_nxt = 4'b0000;
`endif
                end
            end
            S_DRIVE: begin
                if (hold_cnt == HOLD_LAST) begin
                    // This edge ends the hold window, so the gate output is judged here.
                    err_count_nxt = err_inc;
`ifdef GATE_SEQ_FAIL_MASK_EN
                    fail_mask_nxt[vec_idx] = fail_mask[vec_idx] | mismatch;
`endif
                    hold_cnt_nxt = 8'd0;
                    if (vec_idx != 2'd3) begin
                        vec_idx_nxt    = vec_idx + 2'd1;
                        {a_nxt, b_nxt} = vec_idx + 2'd1;
                    end else begin
                        state_nxt   = S_DONE;
                        vec_idx_nxt = 2'd0;
                        a_nxt       = 1'b0;
                        b_nxt       = 1'b0;
                        busy_nxt    = 1'b0;
                        done_nxt    = 1'b1;
                        pass_nxt    = (err_inc == 3'd0);
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            S_DONE: begin
                // The done pulse lasts one cycle. A start seen here is dropped on purpose.
                state_nxt = S_IDLE;
                a_nxt     = 1'b0;
                b_nxt     = 1'b0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
                a_nxt     = 1'b0;
                b_nxt     = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and result registers. Reset abandons any partial run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            hold_cnt  <= 8'd0;
            vec_idx   <= 2'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            vec_idx   <= vec_idx_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_count <= err_count_nxt;
        end
    end

`ifdef GATE_SEQ_FAIL_MASK_EN
    // Per-vector mismatch record. It is held and cleared together with err_count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_mask <= 4'b0000;
        end else begin
            fail_mask <= fail_mask_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench for gate_truth_sequencer.
// dut0 uses the default parameters (NOR table, hold 4). Its y_in is selected from
// a NOR gate, tie-0, tie-1 or an OR gate. dut1 uses hold 1 with the NAND table and
// a NAND gate.
module tb_gate_truth_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    int         mode = 0;

    logic       y0, a0, b0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [1:0] vec0;
    logic       y1, a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [1:0] vec1;
`ifdef GATE_SEQ_FAIL_MASK_EN
    logic [3:0] mask0, mask1;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    // Gate under test for dut0, selected by mode: 0 NOR, 1 tie-0, 2 tie-1, 3 OR.
    always_comb begin
        y0 = 1'b0;
        case (mode)
            0: y0 = ~(a0 | b0);
            1: y0 = 1'b0;
            2: y0 = 1'b1;
            3: y0 = a0 | b0;
            default: y0 = 1'b0;
        endcase
    end

    assign y1 = ~(a1 & b1);

    gate_truth_sequencer dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y_in(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .vec_idx(vec0)
`ifdef GATE_SEQ_FAIL_MASK_EN
        , .fail_mask(mask0)
`endif
    );

    gate_truth_sequencer #(.HOLD_CYCLES(1), .EXP_TABLE(4'b0111)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .vec_idx(vec1)
`ifdef GATE_SEQ_FAIL_MASK_EN
        , .fail_mask(mask1)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One full dut0 run with a start pulse at E0. Checks each cycle of the run,
    // the done cycle, and the cycle after it.
    task automatic run_full(input int m, input int e_err, input int e_mask);
        mode = m;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check("ab",         int'({a0, b0}), j / 4);
            check("vec_idx",    int'(vec0), j / 4);
            check("busy_run",   int'(busy0), 1);
            check("done_early", int'(done0), 0);
            @(negedge clk);
        end
        check("done",      int'(done0), 1);
        check("busy_done", int'(busy0), 0);
        check("ab_done",   int'({a0, b0}), 0);
        check("vec_done",  int'(vec0), 0);
        check("err_count", int'(err0), e_err);
        check("pass",      int'(pass0), (e_err == 0) ? 1 : 0);
`ifdef GATE_SEQ_FAIL_MASK_EN
        check("fail_mask", int'(mask0), e_mask);
`else
        if (e_mask < 0) check("mask_arg", e_mask, 0);
`endif
        @(negedge clk);
        check("done_clear", int'(done0), 0);
        check("err_hold",   int'(err0), e_err);
        check("pass_hold",  int'(pass0), (e_err == 0) ? 1 : 0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ab",   int'({a0, b0}), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_pass", int'(pass0), 0);
        check("rst_err",  int'(err0), 0);
        check("rst_vec",  int'(vec0), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy0), 0);

        run_full(0, 0, 4'b0000);
        run_full(1, 1, 4'b0001);
        run_full(2, 3, 4'b1110);
        run_full(3, 4, 4'b1111);

        // Hold start high for the whole run. The start seen in DONE is dropped, and
        // the next run begins from the IDLE cycle that follows.
        mode = 0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 16; j++) begin
            check("held_ab", int'({a0, b0}), j / 4);
            @(negedge clk);
        end
        check("held_done", int'(done0), 1);
        check("held_pass", int'(pass0), 1);
        @(negedge clk);
        check("held_idle_busy", int'(busy0), 0);
        check("held_idle_done", int'(done0), 0);
        @(negedge clk);
        check("held_restart_busy", int'(busy0), 1);
        check("held_restart_ab",   int'({a0, b0}), 0);
        start0 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Send extra start pulses while busy, then apply an asynchronous reset
        // during vector 2.
        mode = 2;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int j = 0; j < 10; j++) begin
            check("glitch_ab",  int'({a0, b0}), j / 4);
            check("glitch_vec", int'(vec0), j / 4);
            start0 = (j == 2 || j == 6) ? 1'b1 : 1'b0;
            if (j < 9) @(negedge clk);
        end
        start0 = 1'b0;
        check("pre_abort_err", int'(err0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ab",   int'({a0, b0}), 0);
        check("abort_busy", int'(busy0), 0);
        check("abort_vec",  int'(vec0), 0);
        check("abort_err",  int'(err0), 0);
        check("abort_pass", int'(pass0), 0);
        check("abort_done", int'(done0), 0);
`ifdef GATE_SEQ_FAIL_MASK_EN
        check("abort_mask", int'(mask0), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_full(0, 0, 4'b0000);

        // Hold 1 with the NAND table on dut1.
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check("n_ab",   int'({a1, b1}), j);
            check("n_busy", int'(busy1), 1);
            check("n_done_early", int'(done1), 0);
            @(negedge clk);
        end
        check("n_done", int'(done1), 1);
        check("n_pass", int'(pass1), 1);
        check("n_err",  int'(err1), 0);
        check("n_vec",  int'(vec1), 0);
`ifdef GATE_SEQ_FAIL_MASK_EN
        check("n_mask", int'(mask1), 0);
`endif
        @(negedge clk);
        check("n_done_clear", int'(done1), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
